// File: rtl/gray_seq_decoder.sv
// Reflected-gray stream decoder and step checker: registered binary decode, up/down/wrap pulses, and error statistics.
// Optional macro GRAY_DEC_DIR_LOCK_EN adds the DIR input, which makes steps against the locked direction illegal.
module gray_seq_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 CDN,
  input  logic                 CLR,
  input  logic                 VALID,
  input  logic [WIDTH-1:0]     G,
`ifdef GRAY_DEC_DIR_LOCK_EN
  input  logic                 DIR,
`endif
  output logic [WIDTH-1:0]     B,
  output logic                 B_VALID,
  output logic                 UP,
  output logic                 DN,
  output logic                 WRAP,
  output logic                 STEP_ERR,
  output logic                 ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 b_valid_q, b_valid_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;
  logic                 wrap_q, wrap_d;
  logic                 step_err_q, step_err_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] g_bin;
  logic [WIDTH-1:0] diff;
  logic             is_up, is_dn, up_ok, dn_ok, illegal;

  always_comb begin
    g_bin = '0;
    g_bin[WIDTH-1] = G[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      g_bin[WIDTH-1-i] = g_bin[WIDTH-i] ^ G[WIDTH-1-i];
    end
  end

  // b_q always equals decode(previous sample), so it doubles as the reference register
  always_comb begin
    diff  = g_bin - b_q;
    is_up = (diff == WIDTH'(1));
    is_dn = (diff == '1);
`ifdef GRAY_DEC_DIR_LOCK_EN
    up_ok = is_up && !DIR;
    dn_ok = is_dn && DIR;
`else
    up_ok = is_up;
    dn_ok = is_dn;
`endif
    illegal = (diff != '0) && !up_ok && !dn_ok;
  end

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    b_valid_d  = b_valid_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    wrap_d     = 1'b0;
    step_err_d = 1'b0;
    sticky_d   = sticky_q;
    err_cnt_d  = err_cnt_q;
    if (CLR) begin
      state_d   = ST_IDLE;
      b_d       = '0;
      b_valid_d = 1'b0;
      sticky_d  = 1'b0;
      err_cnt_d = '0;
    end else if (VALID) begin
      state_d   = ST_TRACK;
      b_d       = g_bin;
      b_valid_d = 1'b1;
      if (state_q == ST_TRACK) begin
        up_d       = up_ok;
        dn_d       = dn_ok;
        wrap_d     = (up_ok && (b_q == '1)) || (dn_ok && (b_q == '0));
        step_err_d = illegal;
        if (illegal) begin
          sticky_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q    <= ST_IDLE;
      b_q        <= '0;
      b_valid_q  <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      b_valid_q  <= b_valid_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
      sticky_q   <= sticky_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign B          = b_q;
  assign B_VALID    = b_valid_q;
  assign UP         = up_q;
  assign DN         = dn_q;
  assign WRAP       = wrap_q;
  assign STEP_ERR   = step_err_q;
  assign ERR_STICKY = sticky_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Bench for gray_seq_decoder: directed sequences plus random stimulus checked against a table-driven reference model.
module tb_gray_seq_decoder;
  localparam int unsigned W  = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned MAXV = (1 << W) - 1;
  localparam int unsigned EMAX = (1 << EW) - 1;

  logic          clk, cdn, clr, valid, dir;
  logic [W-1:0]  g;
  logic [W-1:0]  b;
  logic          b_valid, up, dn, wrap, step_err, err_sticky;
  logic [EW-1:0] err_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state
  bit          m_have;
  int unsigned m_b, m_cnt;
  bit          m_bv, m_up, m_dn, m_wrap, m_err, m_sticky;

  gray_seq_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .CLK(clk), .CDN(cdn), .CLR(clr), .VALID(valid), .G(g),
`ifdef GRAY_DEC_DIR_LOCK_EN
    .DIR(dir),
`endif
    .B(b), .B_VALID(b_valid), .UP(up), .DN(dn), .WRAP(wrap),
    .STEP_ERR(step_err), .ERR_STICKY(err_sticky), .ERR_CNT(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned gray_of(input int unsigned v);
    return v ^ (v >> 1);
  endfunction

  // inverse gray found by table search over every code
  function automatic int unsigned bin_of(input int unsigned gv);
    for (int unsigned v = 0; v <= MAXV; v++)
      if (gray_of(v) == gv) return v;
    return 0;
  endfunction

  task automatic model_reset();
    m_have = 0; m_b = 0; m_bv = 0; m_cnt = 0;
    m_up = 0; m_dn = 0; m_wrap = 0; m_err = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit v, input int unsigned gv, input bit c, input bit dr);
    int unsigned bin, d;
    bit fwd, bwd;
    m_up = 0; m_dn = 0; m_wrap = 0; m_err = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      bin = bin_of(gv);
      if (m_have) begin
        d = (bin + (MAXV + 1) - m_b) % (MAXV + 1);
        fwd = (d == 1);
        bwd = (d == MAXV);
`ifdef GRAY_DEC_DIR_LOCK_EN
        if (dr) fwd = 0; else bwd = 0;
`endif
        if (d != 0 && !fwd && !bwd) begin
          m_err = 1; m_sticky = 1;
          if (m_cnt < EMAX) m_cnt++;
        end
        m_up = fwd; m_dn = bwd;
        m_wrap = (fwd && m_b == MAXV) || (bwd && m_b == 0);
      end
      m_have = 1; m_b = bin; m_bv = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".B"}, b, m_b);
    check({tag, ".BV"}, b_valid, m_bv);
    check({tag, ".UP"}, up, m_up);
    check({tag, ".DN"}, dn, m_dn);
    check({tag, ".WRAP"}, wrap, m_wrap);
    check({tag, ".SERR"}, step_err, m_err);
    check({tag, ".STICKY"}, err_sticky, m_sticky);
    check({tag, ".CNT"}, err_cnt, m_cnt);
  endtask

  task automatic drive(input string tag, input bit v, input int unsigned gv, input bit c);
    valid = v; g = W'(gv); clr = c;
    @(posedge clk);
    model_step(v, gv, c, dir);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int unsigned cur;
    cdn = 1'b0; clr = 1'b0; valid = 1'b0; g = '0; dir = 1'b0;
    model_reset();
    #3 compare_all("rst");
    #9 cdn = 1'b1;
    drive("idle", 0, 0, 0);
    drive("idle2", 0, 5, 0);

    // full up sequence with wrap
    for (int unsigned i = 0; i <= MAXV; i++) drive("up", 1, gray_of(i), 0);
    check("up_last_b", b, 15);
    drive("up_wrap", 1, 0, 0);
    check("wrap_pulse", wrap, 1);
    check("up_noerr", err_cnt, 0);

    // reverse across zero
    dir = 1'b1;
    drive("clr3", 0, 0, 1);
    drive("dn0", 1, 4'b0000, 0);
    drive("dn1", 1, 4'b1000, 0);
    check("dn_wrap_b", b, 15);
    check("dn_wrap", wrap, 1);
    drive("dn2", 1, 4'b1001, 0);
    check("dn_b14", b, 14);

    // single-bit gray change that is not adjacent
    drive("clr4", 0, 0, 1);
    drive("e0", 1, 4'b0000, 0);
    drive("e1", 1, 4'b0100, 0);
    check("e_b7", b, 7);
    check("e_cnt1", err_cnt, 1);
    drive("e2", 1, 4'b0101, 0);
    check("e_dn", dn, 1);
    drive("hold", 0, 0, 0);

    // saturation of the error counter
    drive("clr5", 0, 0, 1);
    cur = 0;
    drive("s0", 1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      cur = (cur + 2) % (MAXV + 1);
      drive("sat", 1, gray_of(cur), 0);
    end
    check("sat_cnt", err_cnt, EMAX);
    check("sat_serr", step_err, 1);
    drive("clr_valid", 1, gray_of(cur + 1), 1);
    check("clr_bv", b_valid, 0);
    check("clr_cnt", err_cnt, 0);

`ifdef GRAY_DEC_DIR_LOCK_EN
    dir = 1'b0;
    drive("lk0", 1, 4'b0011, 0);
    drive("lk1", 1, 4'b0001, 0);
    check("lk_dn0_serr", step_err, 1);
    dir = 1'b1;
    drive("lk2", 1, 4'b0011, 0);
    drive("lk3", 1, 4'b0001, 0);
    check("lk_dn1_dn", dn, 1);
`endif

    // random: mostly adjacent steps, some holds and jumps, rare clears and resets
    cur = 0;
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4) cur = (cur + 1) % (MAXV + 1);
      else if (r < 7) cur = (cur + MAXV) % (MAXV + 1);
      else if (r < 9) cur = $urandom_range(0, MAXV);
      dir = 1'($urandom_range(0, 1));
      drive("rnd", ($urandom_range(0, 3) != 0), gray_of(cur), ($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #2 cdn = 1'b0;
        #1 model_reset();
        compare_all("arst");
        #1 cdn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
